// File: rtl/mem_stack_sequencer.sv
// rtl/mem_stack_sequencer.sv - stack sequencer for CALL/RET/INT/RTI on the 16-bit data memory port
// Optional stack guard enabled by defining MEM_STACK_GUARD_EN.
module mem_stack_sequencer #(
    parameter int              ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] SP_RESET    = 12'hFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'h800,
    parameter logic [31:0]     INT_VECTOR  = 32'h0000_0010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              rti_req,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       target_pc,
    input  logic [2:0]        flags_in,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              stall,
    output logic              pc_load,
    output logic [31:0]       pc_out,
    output logic              flags_load,
    output logic [2:0]        flags_out,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PUSH_FL = 4'd1;
    localparam logic [3:0] S_PUSH_HI = 4'd2;
    localparam logic [3:0] S_PUSH_LO = 4'd3;
    localparam logic [3:0] S_POP_LO  = 4'd4;
    localparam logic [3:0] S_POP_HI  = 4'd5;
    localparam logic [3:0] S_POP_FL  = 4'd6;
    localparam logic [3:0] S_CAPTURE = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [1:0] OP_CALL = 2'd0;
    localparam logic [1:0] OP_RET  = 2'd1;
    localparam logic [1:0] OP_INT  = 2'd2;
    localparam logic [1:0] OP_RTI  = 2'd3;

    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_LO   = 2'd1;
    localparam logic [1:0] RD_HI   = 2'd2;
    localparam logic [1:0] RD_FL   = 2'd3;

    logic [3:0]        state;
    logic [ADDR_W-1:0] sp;
    logic [1:0]        op;
    logic [31:0]       pc_lat;
    logic [31:0]       tgt_lat;
    logic [2:0]        fl_lat;
    logic [15:0]       rd_lo;
    logic [15:0]       rd_hi;
    logic [2:0]        rd_fl;
    logic [1:0]        rd_sel;
    logic              fault_seq;
    logic              any_req;
    logic              is_push;
    logic              is_pop;
    logic              access_bad;

    assign any_req = int_req | rti_req | ret_req | call_req;
    assign is_push = (state == S_PUSH_FL) || (state == S_PUSH_HI) || (state == S_PUSH_LO);
    assign is_pop  = (state == S_POP_LO) || (state == S_POP_HI) || (state == S_POP_FL);

`ifdef MEM_STACK_GUARD_EN
    logic fault_sticky;

    assign access_bad  = (is_push && (sp < STACK_LIMIT)) || (is_pop && (sp == SP_RESET));
    assign stack_fault = fault_sticky;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_sticky <= 1'b0;
        end else if (access_bad) begin
            fault_sticky <= 1'b1;
        end
    end
`else
    logic unused_guard;

    assign access_bad   = 1'b0;
    assign stack_fault  = 1'b0;
    assign unused_guard = ^STACK_LIMIT;
`endif

    always_comb begin
        mem_we    = is_push && !access_bad;
        mem_re    = is_pop && !access_bad;
        mem_addr  = '0;
        mem_wdata = 16'h0000;
        if (mem_we) begin
            mem_addr = sp;
            case (state)
                S_PUSH_FL: mem_wdata = {13'b0, fl_lat};
                S_PUSH_HI: mem_wdata = pc_lat[31:16];
                default:   mem_wdata = pc_lat[15:0];
            endcase
        end else if (mem_re) begin
            mem_addr = sp + 1'b1;
        end
    end

    // In IDLE the stall follows the request lines directly so the pipeline freezes on the accept cycle.
    always_comb begin
        case (state)
            S_IDLE:  stall = reset && any_req;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    always_comb begin
        pc_load    = (state == S_DONE);
        flags_load = pc_load && (op == OP_RTI) && !fault_seq;
        flags_out  = flags_load ? rd_fl : 3'b000;
        pc_out     = 32'h0;
        if (pc_load) begin
            if (fault_seq) begin
                pc_out = INT_VECTOR;
            end else begin
                case (op)
                    OP_CALL: pc_out = tgt_lat;
                    OP_INT:  pc_out = INT_VECTOR;
                    default: pc_out = {rd_hi, rd_lo};
                endcase
            end
        end
    end

    assign sp_out = sp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sp        <= SP_RESET;
            op        <= OP_CALL;
            pc_lat    <= 32'h0;
            tgt_lat   <= 32'h0;
            fl_lat    <= 3'b000;
            rd_lo     <= 16'h0;
            rd_hi     <= 16'h0;
            rd_fl     <= 3'b000;
            rd_sel    <= RD_NONE;
            fault_seq <= 1'b0;
        end else begin
            // Read data arrives one cycle after mem_re; rd_sel remembers which half it belongs to.
            case (rd_sel)
                RD_LO:   rd_lo <= mem_rdata;
                RD_HI:   rd_hi <= mem_rdata;
                RD_FL:   rd_fl <= mem_rdata[2:0];
                default: ;
            endcase
            if (!mem_re) begin
                rd_sel <= RD_NONE;
            end else if (state == S_POP_LO) begin
                rd_sel <= RD_LO;
            end else if (state == S_POP_HI) begin
                rd_sel <= RD_HI;
            end else begin
                rd_sel <= RD_FL;
            end

            if (access_bad) begin
                fault_seq <= 1'b1;
                state     <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (any_req) begin
                            pc_lat  <= pc_in;
                            tgt_lat <= target_pc;
                            fl_lat  <= flags_in;
                            if (int_req) begin
                                op    <= OP_INT;
                                state <= S_PUSH_FL;
                            end else if (rti_req) begin
                                op    <= OP_RTI;
                                state <= S_POP_LO;
                            end else if (ret_req) begin
                                op    <= OP_RET;
                                state <= S_POP_LO;
                            end else begin
                                op    <= OP_CALL;
                                state <= S_PUSH_HI;
                            end
                        end
                    end
                    S_PUSH_FL: begin sp <= sp - 1'b1; state <= S_PUSH_HI; end
                    S_PUSH_HI: begin sp <= sp - 1'b1; state <= S_PUSH_LO; end
                    S_PUSH_LO: begin sp <= sp - 1'b1; state <= S_DONE;    end
                    S_POP_LO:  begin sp <= sp + 1'b1; state <= S_POP_HI;  end
                    S_POP_HI: begin
                        sp    <= sp + 1'b1;
                        state <= (op == OP_RTI) ? S_POP_FL : S_CAPTURE;
                    end
                    S_POP_FL:  begin sp <= sp + 1'b1; state <= S_CAPTURE; end
                    S_CAPTURE: state <= S_DONE;
                    default: begin
                        fault_seq <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stack_sequencer.sv
// tb/tb_mem_stack_sequencer.sv - self-checking bench for mem_stack_sequencer with a word-level stack model
module tb_mem_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req, call_req, ret_req, rti_req;
    logic [31:0] pc_in, target_pc;
    logic [2:0]  flags_in;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we, mem_re, stall, pc_load, flags_load, stack_fault;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic [11:0] sp_out;

    mem_stack_sequencer dut (
        .clk(clk), .reset(reset),
        .int_req(int_req), .call_req(call_req), .ret_req(ret_req), .rti_req(rti_req),
        .pc_in(pc_in), .target_pc(target_pc), .flags_in(flags_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .stall(stall), .pc_load(pc_load), .pc_out(pc_out),
        .flags_load(flags_load), .flags_out(flags_out),
        .sp_out(sp_out), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    // Plain synchronous RAM standing in for the data memory.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Reference stack: word array plus stack pointer, full-descending.
    logic [15:0] ref_mem [0:4095];
    logic [11:0] ref_sp;
    int          depth;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [11:0] ex_addr [$];
    bit          ex_we [$];
    logic [15:0] ex_data [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input logic [15:0] w);
        ex_addr.push_back(ref_sp);
        ex_we.push_back(1'b1);
        ex_data.push_back(w);
        ref_mem[ref_sp] = w;
        ref_sp = ref_sp - 12'd1;
        depth++;
    endfunction

    function automatic logic [15:0] pop_word();
        ref_sp = ref_sp + 12'd1;
        ex_addr.push_back(ref_sp);
        ex_we.push_back(1'b0);
        ex_data.push_back(16'h0);
        depth--;
        return ref_mem[ref_sp];
    endfunction

    task automatic drop_reqs();
        int_req = 0; call_req = 0; ret_req = 0; rti_req = 0;
    endtask

    task automatic run_op(input logic ri, input logic rr, input logic rt, input logic rc,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] fl);
        int          lat;
        logic [31:0] exp_pc;
        logic        exp_fload;
        logic [2:0]  exp_fl;
        logic [15:0] lo, hi, fw;
        bit          got;
        ex_addr.delete(); ex_we.delete(); ex_data.delete();
        exp_fload = 1'b0;
        exp_fl    = 3'b000;
        if (ri) begin
            push_word({13'b0, fl});
            push_word(pc[31:16]);
            push_word(pc[15:0]);
            exp_pc = 32'h0000_0010;
            lat = 4;
        end else if (rr) begin
            lo = pop_word(); hi = pop_word(); fw = pop_word();
            exp_pc = {hi, lo};
            exp_fload = 1'b1;
            exp_fl = fw[2:0];
            lat = 5;
        end else if (rt) begin
            lo = pop_word(); hi = pop_word();
            exp_pc = {hi, lo};
            lat = 4;
        end else begin
            push_word(pc[31:16]);
            push_word(pc[15:0]);
            exp_pc = tgt;
            lat = 3;
        end

        @(negedge clk);
        int_req = ri; rti_req = rr; ret_req = rt; call_req = rc;
        pc_in = pc; target_pc = tgt; flags_in = fl;
        #1;
        chk("stall_on_accept", stall, 1'b1);
        got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            chk("we_re_exclusive", mem_we & mem_re, 1'b0);
            if (!mem_we) chk("wdata_idle", mem_wdata, 16'h0);
            if (mem_we || mem_re) begin
                if (ex_addr.size() == 0) begin
                    chk("extra_access", 1'b1, 1'b0);
                end else begin
                    chk("access_addr", mem_addr, ex_addr[0]);
                    chk("access_we", mem_we, ex_we[0]);
                    if (ex_we[0]) chk("access_wdata", mem_wdata, ex_data[0]);
                    void'(ex_addr.pop_front()); void'(ex_we.pop_front()); void'(ex_data.pop_front());
                end
            end
            if (pc_load) begin
                got = 1;
                chk("latency", k, lat);
                chk("pc_out", pc_out, exp_pc);
                chk("flags_load", flags_load, exp_fload);
                chk("flags_out", flags_out, exp_fl);
                chk("sp_done", sp_out, ref_sp);
                chk("stall_done", stall, 1'b0);
                drop_reqs();
            end else begin
                chk("stall_busy", stall, 1'b1);
            end
        end
        if (!got) begin
            chk("pc_load_timeout", 1'b0, 1'b1);
            drop_reqs();
        end
        chk("missing_access", ex_addr.size(), 0);
        @(negedge clk);
        chk("pc_load_one_cycle", pc_load, 1'b0);
        chk("stall_idle", stall, 1'b0);
    endtask

    initial begin
        logic [3:0]  b;
        logic        ri, rr, rt, rc;
        bit          seen_re, got;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        mem_rdata = 16'h0;
        ref_sp = 12'hFFF;
        depth = 0;
        reset = 1'b0;
        drop_reqs();
        pc_in = 0; target_pc = 0; flags_in = 0;

        repeat (2) @(negedge clk);
        call_req = 1'b1;
        #1;
        chk("rst_sp", sp_out, 12'hFFF);
        chk("rst_stall", stall, 1'b0);
        chk("rst_we_re", {mem_we, mem_re}, 2'b00);
        chk("rst_addr", mem_addr, 12'h0);
        chk("rst_pc", {pc_load, pc_out}, 33'h0);
        chk("rst_flags", {flags_load, flags_out}, 4'h0);
        chk("rst_fault", stack_fault, 1'b0);
        call_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_op(0, 0, 0, 1, 32'h0001_0004, 32'h0000_0200, 3'b000);
        run_op(0, 0, 1, 0, 32'h0, 32'h0, 3'b000);
        chk("sp_after_ret", sp_out, 12'hFFF);
        run_op(1, 0, 0, 0, 32'h0000_0033, 32'h0, 3'b101);
        run_op(0, 1, 0, 0, 32'h0, 32'h0, 3'b000);
        chk("sp_after_rti", sp_out, 12'hFFF);
        run_op(1, 0, 0, 1, 32'h0000_1234, 32'h0000_0400, 3'b011);
        run_op(0, 0, 0, 1, 32'h0000_5678, 32'h0000_0400, 3'b000);

        // Abort in PUSH_HI: request line held high to prove reset also masks stall.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        ref_sp = 12'hFFF;
        depth = 0;
        @(negedge clk);
        call_req = 1'b1; pc_in = 32'hAAAA_5555; target_pc = 32'h300;
        @(negedge clk);
        chk("pre_abort_we", mem_we, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_we", mem_we, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_sp", sp_out, 12'hFFF);
        chk("abort_pc_load", pc_load, 1'b0);
        call_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_we", mem_we, 1'b0);
        end
        reset = 1'b1;

        for (int n = 0; n < 40; n++) begin
            b = 4'($urandom);
            ri = b[0] & b[1]; rr = b[1]; rt = b[2]; rc = b[3];
            if (!ri && rr && depth < 3) rr = 0;
            if (!ri && rt && depth < 2) rt = 0;
            if (depth > 30) begin ri = 0; rc = 0; rr = 0; rt = 1; end
            if (!(ri | rr | rt | rc)) rc = 1;
            run_op(ri, rr, rt, rc, $urandom, $urandom, 3'($urandom));
        end

`ifdef MEM_STACK_GUARD_EN
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ret_req = 1'b1;
        seen_re = 0;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (mem_re) seen_re = 1;
            if (pc_load) begin
                got = 1;
                chk("guard_pc_out", pc_out, 32'h0000_0010);
                ret_req = 1'b0;
            end
        end
        chk("guard_done_seen", got, 1'b1);
        chk("guard_no_re", seen_re, 1'b0);
        chk("guard_fault", stack_fault, 1'b1);
        ret_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("guard_fault_sticky", stack_fault, 1'b1);
`else
        chk("no_guard_fault", stack_fault, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stack_sequencer.md
Name: mem_stack_sequencer

Overview:
- Multi-cycle controller for the memory stage's data memory port during stack-based control flow: CALL, RET, INT and RTI.
- Owns the stack pointer (SP) and drives memory address, write data and read/write enables.
- The memory is 16 bits wide, so 32-bit PC values are split into two 16-bit halves.
- Stalls the pipeline until the sequence completes, then issues a one-cycle PC load (and a flags load for RTI) to the fetch mux.

Parameters:
- ADDR_W, 12, data memory address width.
- SP_RESET, 12'hFFF, SP value after reset (top of stack).
- STACK_LIMIT, 12'h800, lowest legal push address (used only with the optional guard).
- INT_VECTOR, 32'h0000_0010, PC loaded on interrupt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- int_req  in  1  interrupt request (level).
- call_req  in  1  CALL in memory stage (level).
- ret_req  in  1  RET in memory stage (level).
- rti_req  in  1  RTI in memory stage (level).
- pc_in  in  32  return address to push.
- target_pc  in  32  CALL target.
- flags_in  in  3  flags to push on INT.
- mem_rdata  in  16  memory read data; valid the cycle after mem_re.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  write enable.
- mem_re  out  1  read enable.
- stall  out  1  hold upstream pipeline.
- pc_load  out  1  one-cycle PC load strobe.
- pc_out  out  32  PC to load.
- flags_load  out  1  one-cycle flags restore strobe.
- flags_out  out  3  restored flags.
- sp_out  out  ADDR_W  current SP.
- stack_fault  out  1  sticky stack fault.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE; SP=SP_RESET.
  - All outputs 0, except sp_out=SP_RESET.
  - Reset mid-sequence aborts immediately; no further memory accesses are issued.
- States: IDLE, PUSH_FL, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_FL, CAPTURE, DONE.
- IDLE:
  - Priority when several requests are high: int_req > rti_req > ret_req > call_req.
  - stall is combinational: it goes high in the same cycle any request is high.
  - On accept, latch the operation, pc_in, target_pc and flags_in.
  - Next state: INT→PUSH_FL, CALL→PUSH_HI, RET/RTI→POP_LO.
- Push states:
  - mem_we=1, mem_addr=SP, then SP←SP−1.
  - Write data: PUSH_FL={13'b0,flags}, PUSH_HI=pc[31:16], PUSH_LO=pc[15:0].
  - Order: PUSH_FL→PUSH_HI→PUSH_LO→DONE.
- Pop states:
  - mem_re=1, mem_addr=SP+1, then SP←SP+1.
  - Each read's mem_rdata is captured in the following cycle, so reads are pipelined back to back.
  - Order: POP_LO→POP_HI→(RTI: POP_FL)→CAPTURE.
- CAPTURE: latch the last read's data; no memory access; next state DONE.
- stall is high in every non-IDLE state except DONE.
- DONE:
  - pc_load=1 for one cycle; stall=0; next state IDLE.
  - pc_out: CALL=target_pc, INT=INT_VECTOR, RET/RTI=popped {hi,lo}.
  - flags_load=1 for RTI only, with flags_out=popped word[2:0].
  - Requests are ignored in DONE, so the same instruction is never re-accepted.
- Latency from accept cycle to pc_load: CALL 3, INT 4, RET 4, RTI 5 cycles.
- mem_we and mem_re are never high together. mem_wdata=0 when mem_we=0.
- SP arithmetic is modulo 2^ADDR_W; it wraps silently unless the guard is enabled.
- Requests that arrive while not in IDLE are not queued; the requester holds its level.

Optional Feature:
- Macro: MEM_STACK_GUARD_EN.
- With the macro defined:
  - A push with SP<STACK_LIMIT, or a pop with SP==SP_RESET, suppresses that access.
  - The sequence jumps to DONE and drives pc_out=INT_VECTOR.
  - stack_fault is set and stays set until reset.
- Without the macro: stack_fault is tied to 0 and SP wraps.

Test Plan:
- CALL, pc_in=32'h0001_0004, target_pc=32'h0000_0200, SP=FFF:
  - Writes 0001@FFF, 0004@FFE.
  - pc_load at accept+3 with pc_out=0000_0200; SP=FFD.
- RET immediately after that CALL:
  - Reads FFE, FFF.
  - pc_load at accept+4 with pc_out=0001_0004; SP=FFF.
- INT, flags_in=3'b101, pc_in=32'h0000_0033:
  - Writes 0005@FFF, 0000@FFE, 0033@FFD.
  - pc_out=0000_0010.
  - RTI afterwards restores pc 0000_0033 and flags 101 (flags_load=1); SP=FFF.
- int_req and call_req high in the same cycle: INT sequence only; CALL accepted after DONE→IDLE.
- reset=0 during PUSH_HI: outputs 0 immediately, SP=FFF, no further mem_we.
- MEM_STACK_GUARD_EN defined, RET with SP=FFF: no mem_re, stack_fault=1, pc_out=0000_0010.
